mult_seq_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 15 +
 rtl/mult_seq_ctrl_if.sv | 43 ++++
 rtl/mult_seq_dp.sv | 89 ++++++++
 rtl/mult_seq_ctrl.sv | 100 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared execute-stage types for the iterative multiplier sequencer.
// Build option MULT_EARLY_OUT_EN is consumed by mult_seq_ctrl/mult_seq_dp.
package pipe_pkg;

    localparam int MULT_WIDTH = 32;

    typedef logic [2*MULT_WIDTH-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Request/product handshake between the execute stage and the multiplier.
// master = requester (decode/execute), slave = mult_seq_ctrl.
interface mult_seq_ctrl_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) ();

    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ack;
    logic                 busy;
    logic                 prod_valid;
    logic [2*WIDTH-1:0]   prod;
    logic                 stall;

    modport master (
        output start,
        output is_signed,
        output a,
        output b,
        output ack,
        input  busy,
        input  prod_valid,
        input  prod,
        input  stall
    );

    modport slave (
        input  start,
        input  is_signed,
        input  a,
        input  b,
        input  ack,
        output busy,
        output prod_valid,
        output prod,
        output stall
    );

endinterface

// File: rtl/mult_seq_dp.sv
// Shift-add datapath: operand magnitudes, 2W+1 bit accumulator, sign fix-up.
// MULT_EARLY_OUT_EN adds a zero-detect on the unscanned multiplier bits.
module mult_seq_dp
    import pipe_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_load,
    input  logic                     i_step,
    input  logic                     i_fin,
    input  logic                     i_is_signed,
    input  logic [WIDTH-1:0]         i_a,
    input  logic [WIDTH-1:0]         i_b,
`ifdef MULT_EARLY_OUT_EN
    input  logic [$clog2(WIDTH):0]   i_cnt,
    output logic                     o_rest_zero,
`endif
    output logic [2*WIDTH-1:0]       o_prod
);

    localparam int AW = 2*WIDTH + 1;

    logic [WIDTH-1:0]   r_mcand;
    logic               r_neg;
    logic [AW-1:0]      r_acc;
    logic [2*WIDTH-1:0] r_prod;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [AW-1:0]      w_stepped;
    logic [AW-1:0]      w_acc_nxt;
    logic [2*WIDTH-1:0] w_res;

    assign w_mag_a = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Low half holds the unscanned |b| bits; high half collects partial sums.
    assign w_sum = r_acc[AW-1:WIDTH]
                 + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_stepped = {1'b0, w_sum, r_acc[WIDTH-1:1]};

`ifdef MULT_EARLY_OUT_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] w_mask;
    logic [CNT_W-1:0] w_sh;

    always_comb begin
        w_mask = '1;
        if (i_cnt < CNT_W'(WIDTH))
            w_mask = (WIDTH'(1) << i_cnt) - WIDTH'(1);
        w_mask = w_mask & ~WIDTH'(1);
    end

    // Bits above the current one are all zero: finish the shift in one go.
    assign o_rest_zero = ((r_acc[WIDTH-1:0] & w_mask) == '0);
    assign w_sh        = i_cnt - CNT_W'(1);
    assign w_acc_nxt   = o_rest_zero ? (w_stepped >> w_sh) : w_stepped;
`else
    assign w_acc_nxt = w_stepped;
`endif

    assign w_res = w_acc_nxt[2*WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_prod  <= '0;
        end else begin
            if (i_load) begin
                r_mcand <= w_mag_a;
                r_neg   <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                r_acc   <= {{(WIDTH+1){1'b0}}, w_mag_b};
            end else if (i_step) begin
                r_acc <= w_acc_nxt;
            end
            if (i_fin)
                r_prod <= r_neg ? -w_res : w_res;
        end
    end

    assign o_prod = r_prod;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative multiplier sequencer: FSM, iteration counter, stall/valid outputs.
// Define MULT_EARLY_OUT_EN to finish as soon as the multiplier runs out of ones.
module mult_seq_ctrl
    import pipe_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    mult_seq_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mult_state_e      r_state;
    mult_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load;
    logic             w_step;
    logic             w_fin;
    logic             w_rest_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_fin       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = CNT_W'(WIDTH);
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step    = 1'b1;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1) || w_rest_zero) begin
                    w_fin       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // A new start implies the held product has been taken.
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = CNT_W'(WIDTH);
                    w_state_nxt = RUN;
                end else if (bus.ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    mult_seq_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_fin       (w_fin),
        .i_is_signed (bus.is_signed),
        .i_a         (bus.a),
        .i_b         (bus.b),
`ifdef MULT_EARLY_OUT_EN
        .i_cnt       (r_cnt),
        .o_rest_zero (w_rest_zero),
`endif
        .o_prod      (bus.prod)
    );

`ifndef MULT_EARLY_OUT_EN
    assign w_rest_zero = 1'b0;
`endif

    assign bus.busy       = (r_state == RUN);
    assign bus.prod_valid = (r_state == DONE);
    assign bus.stall      = (bus.start | bus.busy) & ~bus.prod_valid;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed and randomized bench for mult_seq_ctrl against an arithmetic model.
module tb_mult_seq_ctrl;
    import pipe_pkg::*;

    localparam int W = MULT_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   in_done = 1'b0;

    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.WIDTH(W)) bus();

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic prod_t ref_prod(input bit sg, input logic [31:0] a,
                                       input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sg) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return prod_t'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int exp_lat(input bit sg, input logic [31:0] b);
`ifdef MULT_EARLY_OUT_EN
        logic [31:0] m;
        int hb;
        m  = (sg && b[31]) ? -b : b;
        hb = 0;
        for (int i = 0; i < W; i++)
            if (m[i]) hb = i;
        return 2 + hb;
`else
        return W + 1;
`endif
    endfunction

    task automatic run_op(input string tag, input bit sg,
                          input logic [31:0] ia, input logic [31:0] ib,
                          input logic [63:0] exp, input bit with_ack,
                          input bit mid_start);
        int n;
        bus.start     = 1'b1;
        bus.is_signed = sg;
        bus.a         = ia;
        bus.b         = ib;
        bus.ack       = with_ack;
        #1;
        chk({tag, " stall@start"}, 64'(bus.stall), in_done ? 64'd0 : 64'd1);
        cyc();
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        n = 1;
        while (!bus.prod_valid && n < 60) begin
            chk({tag, " busy"}, 64'(bus.busy), 64'd1);
            chk({tag, " stall"}, 64'(bus.stall), 64'd1);
            if (mid_start && n == 5) begin
                bus.start = 1'b1;
                bus.a     = 32'h1234_5678;
                bus.b     = 32'h9ABC_DEF0;
            end else begin
                bus.start = 1'b0;
            end
            cyc();
            n++;
        end
        bus.start = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(exp_lat(sg, ib)));
        chk({tag, " prod"}, bus.prod, exp);
        chk({tag, " busy@done"}, 64'(bus.busy), 64'd0);
        chk({tag, " stall@done"}, 64'(bus.stall), 64'd0);
        in_done = 1'b1;
    endtask

    task automatic consume(input string tag, input logic [63:0] exp);
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        chk({tag, " pv@ack"}, 64'(bus.prod_valid), 64'd0);
        chk({tag, " prod kept"}, bus.prod, exp);
        in_done = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        prod_t       re;

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ack       = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst pv", 64'(bus.prod_valid), 64'd0);
        chk("rst prod", bus.prod, 64'd0);
        chk("rst stall", 64'(bus.stall), 64'd0);

        run_op("u7x6", 1'b0, 32'h7, 32'h6, 64'h2A, 1'b0, 1'b0);
        consume("u7x6", 64'h2A);

        run_op("s-3x5", 1'b1, 32'hFFFF_FFFD, 32'h5,
               64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0);
        consume("s-3x5", 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("u-3x5", 1'b0, 32'hFFFF_FFFD, 32'h5,
               64'h0000_0004_FFFF_FFF1, 1'b0, 1'b0);
        consume("u-3x5", 64'h0000_0004_FFFF_FFF1);

        run_op("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000, 1'b0, 1'b0);
        consume("smin2", 64'h4000_0000_0000_0000);
        run_op("umax2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            bus.a = $urandom;
            cyc();
            chk("hold pv", 64'(bus.prod_valid), 64'd1);
            chk("hold prod", bus.prod, 64'hFFFF_FFFE_0000_0001);
        end
        consume("umax2", 64'hFFFF_FFFE_0000_0001);

        run_op("midstart", 1'b0, 32'h7, 32'h8000_0001,
               64'h0000_0003_8000_0007, 1'b0, 1'b1);
        run_op("b2b", 1'b0, 32'h2, 32'h3, 64'h6, 1'b1, 1'b0);
        consume("b2b", 64'h6);

        run_op("eo_b1", 1'b0, 32'hDEAD_BEEF, 32'h1,
               64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
        consume("eo_b1", 64'h0000_0000_DEAD_BEEF);
        run_op("b0", 1'b1, 32'h8000_0000, 32'h0, 64'h0, 1'b0, 1'b0);
        consume("b0", 64'h0);

        bus.start = 1'b1;
        bus.is_signed = 1'b0;
        bus.a = 32'h5;
        bus.b = 32'hF000_0001;
        cyc();
        bus.start = 1'b0;
        repeat (9) cyc();
        chk("pre-rst busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        cyc();
        chk("midrst busy", 64'(bus.busy), 64'd0);
        chk("midrst pv", 64'(bus.prod_valid), 64'd0);
        chk("midrst prod", bus.prod, 64'd0);
        chk("midrst stall", 64'(bus.stall), 64'd0);
        reset = 1'b0;
        in_done = 1'b0;
        cyc();

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: rb = 32'($urandom_range(0, 255));
                2: ra = (i % 2 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                default: rb = (i % 2 == 0) ? 32'h0 : 32'h8000_0000;
            endcase
            re = ref_prod(rs, ra, rb);
            run_op($sformatf("rnd%0d", i), rs, ra, rb, re,
                   1'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1)
                consume($sformatf("rnd%0d", i), re);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
